// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between move, setup and board-dump sources.
// Fixed priority setup > move > dump chunk, re-evaluated at every frame boundary.
module uart_tx_scheduler #(
  parameter int unsigned FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_req,
  input  logic [11:0]        move_packet,
  input  logic               setup_req,
  input  logic [13:0]        setup_data,
  input  logic               dump_req,
  input  logic [255:0]       board_flat,
  output logic [FRAME_W-1:0] tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               move_sent,
  output logic               dump_done,
  output logic               overrun
);

  typedef enum logic {StIdle, StSend} state_e;
  typedef enum logic [1:0] {SrcMove, SrcSetup, SrcDump} src_e;

  state_e               state_q, state_d;
  src_e                 src_q, src_d;
  logic                 move_pend_q, move_pend_d;
  logic [11:0]          move_data_q, move_data_d;
  logic                 setup_pend_q, setup_pend_d;
  logic [13:0]          setup_data_q, setup_data_d;
  logic                 dump_active_q, dump_active_d;
  logic [255:0]         snap_q, snap_d;
  logic [4:0]           chunk_q, chunk_d;
  logic [FRAME_W-1:0]   tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 move_sent_q, move_sent_d;
  logic                 dump_done_q, dump_done_d;
  logic                 overrun_q, overrun_d;
  logic                 grant_move, grant_setup;
  logic [7:0]           dump_byte;
  logic [FRAME_W-1:0]   dump_frame;

  // Chunk k covers squares 2k (low nibble) and 2k+1 (high nibble) of the snapshot.
  assign dump_byte  = snap_q[{chunk_q, 3'b000} +: 8];
  assign dump_frame = {2'b01, chunk_q, 1'b0, dump_byte[3:0], dump_byte[7:4]};

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    move_pend_d   = move_pend_q;
    move_data_d   = move_data_q;
    setup_pend_d  = setup_pend_q;
    setup_data_d  = setup_data_q;
    dump_active_d = dump_active_q;
    snap_d        = snap_q;
    chunk_d       = chunk_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    move_sent_d   = 1'b0;
    dump_done_d   = 1'b0;
    overrun_d     = overrun_q;
    grant_move    = 1'b0;
    grant_setup   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (setup_pend_q) begin
          tx_data_d    = {2'b10, setup_data_q};
          tx_valid_d   = 1'b1;
          setup_pend_d = 1'b0;
          grant_setup  = 1'b1;
          src_d        = SrcSetup;
          state_d      = StSend;
        end else if (move_pend_q) begin
          tx_data_d   = {4'b0000, move_data_q};
          tx_valid_d  = 1'b1;
          move_pend_d = 1'b0;
          grant_move  = 1'b1;
          src_d       = SrcMove;
          state_d     = StSend;
        end else if (dump_active_q) begin
          tx_data_d  = dump_frame;
          tx_valid_d = 1'b1;
          src_d      = SrcDump;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
          if (src_q == SrcMove) begin
            move_sent_d = 1'b1;
          end
          if (src_q == SrcDump) begin
            chunk_d = chunk_q + 5'd1;
            if (chunk_q == 5'd31) begin
              dump_active_d = 1'b0;
              dump_done_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // New requests win over the grant-time clear so a same-edge request re-arms the slot.
    if (move_req) begin
      move_pend_d = 1'b1;
      move_data_d = move_packet;
      if (move_pend_q && !grant_move) begin
        overrun_d = 1'b1;
      end
    end
    if (setup_req) begin
      setup_pend_d = 1'b1;
      setup_data_d = setup_data;
      if (setup_pend_q && !grant_setup) begin
        overrun_d = 1'b1;
      end
    end
    if (dump_req && !dump_active_q) begin
      snap_d        = board_flat;
      chunk_d       = 5'd0;
      dump_active_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      src_q         <= SrcMove;
      move_pend_q   <= 1'b0;
      move_data_q   <= '0;
      setup_pend_q  <= 1'b0;
      setup_data_q  <= '0;
      dump_active_q <= 1'b0;
      snap_q        <= '0;
      chunk_q       <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      move_sent_q   <= 1'b0;
      dump_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      move_pend_q   <= move_pend_d;
      move_data_q   <= move_data_d;
      setup_pend_q  <= setup_pend_d;
      setup_data_q  <= setup_data_d;
      dump_active_q <= dump_active_d;
      snap_q        <= snap_d;
      chunk_q       <= chunk_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      move_sent_q   <= move_sent_d;
      dump_done_q   <= dump_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign move_sent = move_sent_q;
  assign dump_done = dump_done_q;
  assign overrun   = overrun_q;
  assign busy      = move_pend_q | setup_pend_q | dump_active_q | (state_q == StSend);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus random traffic, all outputs
// compared every cycle against a slot/queue level model of the scheduler.
module tb_uart_tx_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         move_req, setup_req, dump_req, tx_ready;
  logic [11:0]  move_packet;
  logic [13:0]  setup_data;
  logic [255:0] board_flat;
  logic [15:0]  tx_data;
  logic         tx_valid, busy, move_sent, dump_done, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sent_log[$];

  // Model state: what must be outstanding and what must be on the wire.
  bit          m_move_pend, m_setup_pend, m_dump_on, m_inflight, m_ovr, m_ms, m_dd;
  int          m_move_pkt, m_setup_dat, m_chunk, m_kind;  // kind 0 move, 1 setup, 2 dump
  int          m_sq[64];
  logic [15:0] m_frame;

  uart_tx_scheduler #(.FRAME_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .move_req    (move_req),
    .move_packet (move_packet),
    .setup_req   (setup_req),
    .setup_data  (setup_data),
    .dump_req    (dump_req),
    .board_flat  (board_flat),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .move_sent   (move_sent),
    .dump_done   (dump_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] chunk_frame(input int k);
    int v;
    v = 'h4000 + (2 * k) * 256 + m_sq[2 * k] * 16 + m_sq[2 * k + 1];
    return 16'(v);
  endfunction

  task automatic model_clear();
    m_move_pend = 0; m_setup_pend = 0; m_dump_on = 0; m_inflight = 0;
    m_ovr = 0; m_ms = 0; m_dd = 0; m_chunk = 0; m_kind = 0; m_frame = '0;
    m_move_pkt = 0; m_setup_dat = 0;
  endtask

  // Inputs only change just after a rising edge, so at the falling edge they already
  // hold the values the next rising edge will see.
  always @(negedge clk) begin
    if (reset) begin
      model_clear();
      check("reset_tx_valid", tx_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_outputs", {tx_data, move_sent, dump_done, overrun}, 0);
    end else begin
      bit was_dumping;
      check("tx_valid", tx_valid, m_inflight);
      check("tx_data", tx_data, m_frame);
      check("busy", busy, m_move_pend | m_setup_pend | m_dump_on | m_inflight);
      check("move_sent", move_sent, m_ms);
      check("dump_done", dump_done, m_dd);
      check("overrun", overrun, m_ovr);
      if (tx_valid && tx_ready) sent_log.push_back(tx_data);

      was_dumping = m_dump_on;
      m_ms = 0;
      m_dd = 0;
      if (m_inflight) begin
        if (tx_ready) begin
          m_inflight = 0;
          if (m_kind == 0) m_ms = 1;
          if (m_kind == 2) begin
            m_chunk++;
            if (m_chunk == 32) begin
              m_chunk = 0;
              m_dump_on = 0;
              m_dd = 1;
            end
          end
        end
      end else if (m_setup_pend) begin
        m_frame = 16'('h8000 + m_setup_dat); m_kind = 1; m_setup_pend = 0; m_inflight = 1;
      end else if (m_move_pend) begin
        m_frame = 16'(m_move_pkt); m_kind = 0; m_move_pend = 0; m_inflight = 1;
      end else if (m_dump_on) begin
        m_frame = chunk_frame(m_chunk); m_kind = 2; m_inflight = 1;
      end
      if (move_req) begin
        if (m_move_pend) m_ovr = 1;
        m_move_pend = 1;
        m_move_pkt = int'(move_packet);
      end
      if (setup_req) begin
        if (m_setup_pend) m_ovr = 1;
        m_setup_pend = 1;
        m_setup_dat = int'(setup_data);
      end
      if (dump_req && !was_dumping) begin
        for (int i = 0; i < 64; i++) m_sq[i] = int'(board_flat[4 * i +: 4]);
        m_chunk = 0;
        m_dump_on = 1;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ramp_board();
    for (int i = 0; i < 64; i++) board_flat[4 * i +: 4] = 4'(i);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin cycle(); n++; end
    check(name, busy, 0);
  endtask

  task automatic wait_frame(input string name, input logic [15:0] v);
    int n = 0;
    while (!(tx_valid && tx_data == v) && n < 300) begin cycle(); n++; end
    check(name, tx_data, v);
  endtask

  initial begin
    reset = 1'b1; move_req = 0; setup_req = 0; dump_req = 0; tx_ready = 0;
    move_packet = '0; setup_data = '0; board_flat = '0;
    model_clear();
    repeat (3) cycle();
    check("por_state", {tx_valid, busy, overrun, tx_data}, 0);
    reset = 1'b0;
    cycle();

    // Single move, two-edge latency, one-cycle valid.
    tx_ready = 1; move_packet = 12'hA5C; move_req = 1;
    cycle();
    move_req = 0;
    check("move_not_yet", tx_valid, 0);
    cycle();
    check("move_valid", tx_valid, 1);
    check("move_frame", tx_data, 16'h0A5C);
    cycle();
    check("move_sent_pulse", move_sent, 1);
    check("move_valid_drop", tx_valid, 0);
    check("move_busy_low", busy, 0);
    cycle();
    check("move_sent_once", move_sent, 0);

    // Setup held under backpressure.
    tx_ready = 0; setup_data = 14'h1234; setup_req = 1;
    cycle();
    setup_req = 0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {15'd0, tx_valid, tx_data}, {15'd0, 1'b1, 16'h9234});
      cycle();
    end
    sent_log.delete();
    tx_ready = 1;
    cycle();
    check("bp_accepted", tx_valid, 0);
    check("bp_log", sent_log.size() == 1 ? sent_log[0] : 16'hDEAD, 16'h9234);

    // Full dump; board scrambled mid-dump must not leak into frames.
    wait_idle("idle_before_dump");
    sent_log.delete();
    ramp_board();
    dump_req = 1;
    cycle();
    dump_req = 0;
    repeat (20) cycle();
    for (int i = 0; i < 8; i++) board_flat[32 * i +: 32] = $urandom();
    wait_idle("dump_complete");
    check("dump_count", sent_log.size(), 32);
    if (sent_log.size() == 32) begin
      check("dump_chunk0", sent_log[0], 16'h4001);
      check("dump_chunk5", sent_log[5], 16'h4AAB);
      check("dump_chunk31", sent_log[31], 16'h7EEF);
    end

    // Move injected while chunk 5 is on the wire.
    sent_log.delete();
    ramp_board();
    dump_req = 1;
    cycle();
    dump_req = 0;
    wait_frame("see_chunk5", 16'h4AAB);
    move_packet = 12'h123; move_req = 1;
    cycle();
    move_req = 0;
    wait_idle("interleave_done");
    check("interleave_count", sent_log.size(), 33);
    if (sent_log.size() == 33) begin
      check("interleave_chunk5", sent_log[5], 16'h4AAB);
      check("interleave_move", sent_log[6], 16'h0123);
      check("interleave_chunk6", sent_log[7], 16'h4CCD);
    end

    // Setup beats move when both land together.
    sent_log.delete();
    setup_data = 14'h0005; setup_req = 1; move_packet = 12'h0F0; move_req = 1;
    cycle();
    setup_req = 0; move_req = 0;
    wait_idle("prio_done");
    check("prio_count", sent_log.size(), 2);
    if (sent_log.size() == 2) begin
      check("prio_first", sent_log[0], 16'h8005);
      check("prio_second", sent_log[1], 16'h00F0);
    end

    // Overrun: second move overwrites first while a setup blocks the link.
    sent_log.delete();
    tx_ready = 0; setup_data = 14'h0777; setup_req = 1;
    cycle();
    setup_req = 0; move_packet = 12'h111; move_req = 1;
    cycle();
    move_req = 0;
    check("ovr_not_yet", overrun, 0);
    cycle();
    cycle();
    move_packet = 12'h222; move_req = 1;
    cycle();
    move_req = 0;
    check("ovr_set", overrun, 1);
    tx_ready = 1;
    wait_idle("ovr_drain");
    check("ovr_sticky", overrun, 1);
    check("ovr_count", sent_log.size(), 2);
    if (sent_log.size() == 2) check("ovr_second_pkt", sent_log[1], 16'h0222);

    // Asynchronous reset mid-dump.
    ramp_board();
    dump_req = 1;
    cycle();
    dump_req = 0;
    wait_frame("see_chunk12", 16'h5889);
    reset = 1;
    #1;
    check("rst_valid_async", tx_valid, 0);
    check("rst_busy_async", busy, 0);
    check("rst_overrun_async", overrun, 0);
    cycle();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("rst_quiet", {tx_valid, busy}, 0);
    end

    // Random traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      tx_ready    = ($urandom_range(3) != 0);
      move_req    = ($urandom_range(15) == 0);
      setup_req   = ($urandom_range(19) == 0);
      dump_req    = ($urandom_range(59) == 0);
      move_packet = 12'($urandom());
      setup_data  = 14'($urandom());
      for (int i = 0; i < 8; i++) board_flat[32 * i +: 32] = $urandom();
      reset       = ($urandom_range(799) == 0);
      cycle();
    end
    move_req = 0; setup_req = 0; dump_req = 0; reset = 0; tx_ready = 1;
    wait_idle("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
